// File: rtl/sad_row_engine.sv
// sad_row_engine
// Sum-of-absolute-differences engine for block motion search. Each search
// walks NUM_CAND candidate blocks of BLK_ROWS rows. For every accepted row it
// registers the per-pixel absolute differences, reduces them to a row sum,
// and accumulates the sums per candidate. It reports each candidate's SAD and
// keeps the running minimum with its index.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; aborts any search in flight
//   start      one-cycle pulse in IDLE begins a search
//   cur_row    current-block row, pixel i at [PIX_W*i +: PIX_W]
//   ref_row    reference row, same packing
//   row_valid  cur_row/ref_row carry a beat this cycle
//   en_out     read request to the current-block buffer (high while RUN)
//   sad_out    SAD of the most recently completed candidate
//   sad_valid  one-cycle pulse per completed candidate
//   sad_idx    candidate index belonging to sad_out
//   best_sad   minimum SAD seen in this search
//   best_idx   index of that minimum (earliest index wins ties)
//   done       one-cycle pulse once best_* are final
//   busy       high from start until the cycle after done
module sad_row_engine #(
  parameter int PIX_W    = 8,
  parameter int ROW_PIX  = 8,
  parameter int BLK_ROWS = 16,
  parameter int NUM_CAND = 9,
  parameter int SAD_W    = 16,
  parameter int IDX_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PIX_W*ROW_PIX-1:0] cur_row,
  input  logic [PIX_W*ROW_PIX-1:0] ref_row,
  input  logic                     row_valid,
  output logic                     en_out,
  output logic [SAD_W-1:0]         sad_out,
  output logic                     sad_valid,
  output logic [IDX_W-1:0]         sad_idx,
  output logic [SAD_W-1:0]         best_sad,
  output logic [IDX_W-1:0]         best_idx,
  output logic                     done,
  output logic                     busy
);

  localparam int SUM_W = PIX_W + $clog2(ROW_PIX);
  localparam int RCW   = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // |a - b| formed on a one-bit-wider signed difference so 0 - 255 is exact.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    logic signed [PIX_W:0] d;
    logic signed [PIX_W:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    return d[PIX_W] ? n[PIX_W-1:0] : d[PIX_W-1:0];
  endfunction

  function automatic logic [SUM_W-1:0] row_sum(
      input logic [ROW_PIX-1:0][PIX_W-1:0] d);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < ROW_PIX; i++) s = s + SUM_W'(d[i]);
    return s;
  endfunction

  state_t                       r_state;
  logic [RCW-1:0]               r_row_cnt;
  logic [IDX_W-1:0]             r_cand_cnt;
  logic [ROW_PIX-1:0][PIX_W-1:0] r_diff_p1;
  logic                         r_vld_p1, r_last_p1;
  logic [IDX_W-1:0]             r_idx_p1;
  logic [SUM_W-1:0]             r_sum_p2;
  logic                         r_vld_p2, r_last_p2;
  logic [IDX_W-1:0]             r_idx_p2;
  logic [SAD_W-1:0]             r_acc;
  logic [SAD_W-1:0]             r_sad_out, r_best_sad;
  logic [IDX_W-1:0]             r_sad_idx, r_best_idx;
  logic                         r_sad_valid, r_done, r_busy;

  logic                          w_accept, w_last_row, w_last_cand, w_final;
  logic [ROW_PIX-1:0][PIX_W-1:0] w_diff;

  assign w_accept    = row_valid && (r_state == RUN);
  assign w_last_row  = (r_row_cnt == RCW'(BLK_ROWS - 1));
  assign w_last_cand = (r_cand_cnt == IDX_W'(NUM_CAND - 1));
  // Final candidate's compare happens on the edge after its sad_valid pulse.
  assign w_final     = r_sad_valid && (r_sad_idx == IDX_W'(NUM_CAND - 1));

  always_comb begin
    w_diff = '0;
    for (int i = 0; i < ROW_PIX; i++)
      w_diff[i] = abs_diff(cur_row[PIX_W*i +: PIX_W], ref_row[PIX_W*i +: PIX_W]);
  end

  // Datapath registers: qualified by the valid tags, so they need no reset.
  always_ff @(posedge clk) begin
    // stage 1: per-pixel absolute differences plus beat tags
    r_diff_p1 <= w_diff;
    r_last_p1 <= w_last_row;
    r_idx_p1  <= r_cand_cnt;
    // stage 2: row sum
    r_sum_p2  <= row_sum(r_diff_p1);
    r_last_p2 <= r_last_p1;
    r_idx_p2  <= r_idx_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row_cnt   <= '0;
      r_cand_cnt  <= '0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_acc       <= '0;
      r_sad_out   <= '0;
      r_sad_idx   <= '0;
      r_sad_valid <= 1'b0;
      r_best_sad  <= '0;
      r_best_idx  <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sad_valid <= 1'b0;
      r_done      <= 1'b0;
      r_vld_p1    <= w_accept;
      r_vld_p2    <= r_vld_p1;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_row_cnt  <= '0;
            r_cand_cnt <= '0;
            r_acc      <= '0;
            r_best_sad <= '1;
            r_best_idx <= '0;
            r_busy     <= 1'b1;
          end else if (r_done) begin
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          if (row_valid) begin
            if (w_last_row) begin
              r_row_cnt <= '0;
              if (w_last_cand) r_state <= DRAIN;
              else             r_cand_cnt <= r_cand_cnt + IDX_W'(1);
            end else begin
              r_row_cnt <= r_row_cnt + RCW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_final) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // stage 3: accumulate; a last-row beat closes the candidate and clears
      // the accumulator on the same edge so the next candidate follows directly
      if (r_vld_p2) begin
        if (r_last_p2) begin
          r_sad_out   <= r_acc + SAD_W'(r_sum_p2);
          r_sad_idx   <= r_idx_p2;
          r_sad_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= r_acc + SAD_W'(r_sum_p2);
        end
      end

      // stage 4: strict-less compare keeps the earliest index on ties
      if (r_sad_valid && (r_sad_out < r_best_sad)) begin
        r_best_sad <= r_sad_out;
        r_best_idx <= r_sad_idx;
      end
    end
  end

  assign en_out    = (r_state == RUN);
  assign sad_out   = r_sad_out;
  assign sad_valid = r_sad_valid;
  assign sad_idx   = r_sad_idx;
  assign best_sad  = r_best_sad;
  assign best_idx  = r_best_idx;
  assign done      = r_done;
  assign busy      = r_busy;

endmodule
